// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax pipeline: arithmetic selectors, the zero
// constant and the accumulator control states.
package softmax_pkg;

  localparam int ARITH_FLOAT = 0;
  localparam int ARITH_FIXED = 1;

  // All-zeros is zero in both float and two's-complement fixed formats.
  localparam logic [63:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/exp_sum_accumulator_adder.sv
// Combinational adder/subtractor: wrapping two's-complement fixed point, or
// IEEE-style float with round-to-nearest-even and denormals flushed to zero.
module adder
  import softmax_pkg::*;
#(
  parameter int ARITH_TYPE = ARITH_FLOAT,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int INTEGER    = 12,
  parameter int FRACTION   = 20
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_sub,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int FMT_W = (ARITH_TYPE == ARITH_FIXED) ? INTEGER + FRACTION : 1 + E + M;

  generate
    if (ARITH_TYPE == ARITH_FIXED) begin : g_fixed
      logic [FMT_W-1:0] w_a;
      logic [FMT_W-1:0] w_b;
      logic [FMT_W-1:0] w_sum;

      assign w_a      = i_a[FMT_W-1:0];
      assign w_b      = i_b[FMT_W-1:0];
      assign w_sum    = i_sub ? (w_a - w_b) : (w_a + w_b);
      assign o_result = DATA_WIDTH'(w_sum);
    end else begin : g_float
      localparam int MW   = M + 4;  // hidden bit, M fraction bits, guard/round/sticky
      localparam int EW   = E + 2;
      localparam int EMAX = (1 << E) - 1;

      logic              w_sa, w_sb, w_s_big, w_s_small, w_a_big;
      logic [E-1:0]      w_ea, w_eb, w_e_big, w_e_small;
      logic [M-1:0]      w_fa, w_fb, w_frac;
      logic [M:0]        w_m_big, w_m_small;
      logic [31:0]       w_shift;
      logic [MW-1:0]     w_al;
      logic [MW:0]       w_n;
      logic signed [EW-1:0] w_e;
      logic              w_up;
      logic [M:0]        w_r;
      logic [DATA_WIDTH-1:0] w_res;

      always_comb begin
        w_sa = i_a[FMT_W-1];
        w_ea = i_a[FMT_W-2 -: E];
        w_fa = (w_ea == '0) ? '0 : i_a[M-1:0];
        w_sb = i_b[FMT_W-1] ^ i_sub;
        w_eb = i_b[FMT_W-2 -: E];
        w_fb = (w_eb == '0) ? '0 : i_b[M-1:0];

        w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
        if (w_a_big) begin
          w_s_big = w_sa;  w_e_big = w_ea;  w_m_big = {|w_ea, w_fa};
          w_s_small = w_sb; w_e_small = w_eb; w_m_small = {|w_eb, w_fb};
        end else begin
          w_s_big = w_sb;  w_e_big = w_eb;  w_m_big = {|w_eb, w_fb};
          w_s_small = w_sa; w_e_small = w_ea; w_m_small = {|w_ea, w_fa};
        end

        // Right-align the smaller operand, folding shifted-out bits into bit 0.
        w_shift = 32'(w_e_big) - 32'(w_e_small);
        w_al    = {w_m_small, 3'b000};
        for (int unsigned i = 0; i < MW; i++) begin
          if (i < w_shift) w_al = {1'b0, w_al[MW-1:2], w_al[1] | w_al[0]};
        end

        w_e = $signed({2'b00, w_e_big});
        if (w_s_big == w_s_small) w_n = {1'b0, w_m_big, 3'b000} + {1'b0, w_al};
        else                      w_n = {1'b0, w_m_big, 3'b000} - {1'b0, w_al};

        if (w_n[MW]) begin
          w_n = {1'b0, w_n[MW:2], w_n[1] | w_n[0]};
          w_e = w_e + EW'(1);
        end else begin
          for (int unsigned i = 0; i < MW; i++) begin
            if (!w_n[MW-1] && (w_n != '0)) begin
              w_n = w_n << 1;
              w_e = w_e - EW'(1);
            end
          end
        end

        w_up   = w_n[2] & ((|w_n[1:0]) | w_n[3]);
        w_r    = {1'b0, w_n[MW-2:3]} + (M+1)'(w_up);
        w_frac = w_r[M-1:0];
        if (w_r[M]) begin
          w_e    = w_e + EW'(1);
          w_frac = '0;
        end

        w_res = '0;
        if (w_ea == '1)                  w_res = i_a;
        else if (w_eb == '1)             w_res = DATA_WIDTH'({w_sb, i_b[FMT_W-2:0]});
        else if ((w_n == '0) || (w_e <= 0)) w_res = '0;
        else if (int'(w_e) >= EMAX)      w_res = DATA_WIDTH'({w_s_big, {E{1'b1}}, {M{1'b0}}});
        else                             w_res = DATA_WIDTH'({w_s_big, w_e[E-1:0], w_frac});
      end

      assign o_result = w_res;
    end
  endgenerate

endmodule

// File: rtl/exp_sum_accumulator.sv
// Softmax denominator: sums VEC_LEN exponential elements per vector and holds
// the total for the divider until it is taken.
module exp_sum_accumulator
  import softmax_pkg::*;
#(
  parameter int ARITH_TYPE = ARITH_FLOAT,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int INTEGER    = 12,
  parameter int FRACTION   = 20,
  parameter int VEC_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [DATA_WIDTH-1:0] sum_data,
  output logic                  busy
);

  localparam int              CW   = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0]   LAST = CW'(VEC_LEN - 1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_acc, r_sum, w_add_a, w_add_y;
  logic [CW-1:0]         r_count;
  logic                  w_in_ready, w_accept, w_last;

  // in_ready is forced low while reset is held, even though IDLE accepts beats.
  assign w_in_ready = rst_n & (r_state != DONE);
  assign w_accept   = in_valid & w_in_ready & ~flush;
  assign w_last     = (r_count == LAST);
  assign w_add_a    = (r_count == '0) ? DATA_WIDTH'(ZERO) : r_acc;

  adder #(
    .ARITH_TYPE (ARITH_TYPE),
    .DATA_WIDTH (DATA_WIDTH),
    .E          (E),
    .M          (M),
    .INTEGER    (INTEGER),
    .FRACTION   (FRACTION)
  ) u_adder (
    .i_a      (w_add_a),
    .i_b      (in_data),
    .i_sub    (1'b0),
    .o_result (w_add_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ACC;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = (w_accept && w_last) ? DONE : ACC;
        ACC:     if (w_accept && w_last) w_state_nxt = DONE;
        DONE:    if (sum_ready) w_state_nxt = ACC;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sum   <= w_add_y;
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_acc   <= w_add_y;
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign sum_valid = (r_state == DONE);
  assign sum_data  = r_sum;
  assign busy      = (r_count != '0);

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// Directed bench for exp_sum_accumulator: fixed Q12.20 and float instances with
// VEC_LEN=4, plus a fixed VEC_LEN=1 pass-through instance.
module tb_exp_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic        f_flush = 0, f_in_valid = 0, f_sum_ready = 0;
  logic [31:0] f_in_data = '0;
  logic        f_in_ready, f_sum_valid, f_busy;
  logic [31:0] f_sum_data;

  logic        g_flush = 0, g_in_valid = 0, g_sum_ready = 0;
  logic [31:0] g_in_data = '0;
  logic        g_in_ready, g_sum_valid, g_busy;
  logic [31:0] g_sum_data;

  logic        h_flush = 0, h_in_valid = 0, h_sum_ready = 0;
  logic [31:0] h_in_data = '0;
  logic        h_in_ready, h_sum_valid, h_busy;
  logic [31:0] h_sum_data;

  exp_sum_accumulator #(.ARITH_TYPE(1), .DATA_WIDTH(32), .INTEGER(12), .FRACTION(20), .VEC_LEN(4)) u_fix (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_data(f_in_data), .sum_valid(f_sum_valid), .sum_ready(f_sum_ready), .sum_data(f_sum_data), .busy(f_busy));

  exp_sum_accumulator #(.ARITH_TYPE(0), .DATA_WIDTH(32), .E(8), .M(23), .VEC_LEN(4)) u_flt (
    .clk(clk), .rst_n(rst_n), .flush(g_flush), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_data(g_in_data), .sum_valid(g_sum_valid), .sum_ready(g_sum_ready), .sum_data(g_sum_data), .busy(g_busy));

  exp_sum_accumulator #(.ARITH_TYPE(1), .DATA_WIDTH(32), .INTEGER(12), .FRACTION(20), .VEC_LEN(1)) u_one (
    .clk(clk), .rst_n(rst_n), .flush(h_flush), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .sum_valid(h_sum_valid), .sum_ready(h_sum_ready), .sum_data(h_sum_data), .busy(h_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_beat(input logic [31:0] d);
    int unsigned w = 0;
    while (f_in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    if (w >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL f_beat_timeout in_ready=%b required=1", f_in_ready);
    end else begin
      f_in_valid = 1; f_in_data = d; tick(); f_in_valid = 0;
    end
  endtask

  task automatic g_beat(input logic [31:0] d);
    int unsigned w = 0;
    while (g_in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    if (w >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL g_beat_timeout in_ready=%b required=1", g_in_ready);
    end else begin
      g_in_valid = 1; g_in_data = d; tick(); g_in_valid = 0;
    end
  endtask

  task automatic f_take();
    f_sum_ready = 1; tick(); f_sum_ready = 0;
  endtask

  task automatic g_take();
    g_sum_ready = 1; tick(); g_sum_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick(); tick();
    n_cmp++;
    if ({f_in_ready, f_sum_valid, f_busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl rdy/vld/busy=%b required=000", {f_in_ready, f_sum_valid, f_busy});
    end
    n_cmp++;
    if (f_sum_data !== 32'h0) begin
      n_err++; $display("FAIL reset_sum actual=%h required=00000000", f_sum_data);
    end
    n_cmp++;
    if ({g_in_ready, g_sum_valid, h_in_ready, h_sum_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_other actual=%b required=0000", {g_in_ready, g_sum_valid, h_in_ready, h_sum_valid});
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if ({f_in_ready, f_sum_valid, f_busy} !== 3'b100) begin
      n_err++; $display("FAIL post_reset rdy/vld/busy=%b required=100", {f_in_ready, f_sum_valid, f_busy});
    end
  endtask

  task automatic test_fixed_b2b();
    for (int i = 0; i < 4; i++) begin
      f_in_valid = 1; f_in_data = 32'h0010_0000; tick();
      if (i < 3) begin
        n_cmp++;
        if ({f_sum_valid, f_busy} !== 2'b01) begin
          n_err++; $display("FAIL b2b_beat%0d vld/busy=%b required=01", i, {f_sum_valid, f_busy});
        end
      end
    end
    f_in_valid = 0;
    n_cmp++;
    if ({f_sum_valid, f_in_ready, f_busy} !== 3'b100) begin
      n_err++; $display("FAIL b2b_done vld/rdy/busy=%b required=100", {f_sum_valid, f_in_ready, f_busy});
    end
    n_cmp++;
    if (f_sum_data !== 32'h0040_0000) begin
      n_err++; $display("FAIL b2b_sum actual=%h required=00400000", f_sum_data);
    end
    f_take();
    n_cmp++;
    if ({f_sum_valid, f_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL b2b_handshake vld/rdy=%b required=01", {f_sum_valid, f_in_ready});
    end
  endtask

  task automatic test_float();
    logic [31:0] vecs [4][4];
    logic [31:0] exp_sum [4];
    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F80_0000}; exp_sum[0] = 32'h4100_0000;
    vecs[1] = '{32'h3FC0_0000, 32'hBF00_0000, 32'h3E80_0000, 32'h4040_0000}; exp_sum[1] = 32'h4088_0000;
    vecs[2] = '{32'h3F80_0000, 32'hBF80_0000, 32'h40A0_0000, 32'h3F00_0000}; exp_sum[2] = 32'h40B0_0000;
    vecs[3] = '{32'h3F80_0001, 32'h3380_0000, 32'h0000_0000, 32'h0000_0000}; exp_sum[3] = 32'h3F80_0002;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) g_beat(vecs[v][i]);
      n_cmp++;
      if (g_sum_valid !== 1'b1 || g_sum_data !== exp_sum[v]) begin
        n_err++; $display("FAIL float_vec%0d vld=%b sum=%h required vld=1 sum=%h", v, g_sum_valid, g_sum_data, exp_sum[v]);
      end
      g_take();
    end
  endtask

  task automatic test_fixed_wrap();
    f_beat(32'h7FF0_0000); f_beat(32'h0010_0000); f_beat(32'h0010_0000); f_beat(32'h0000_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h8010_0000) begin
      n_err++; $display("FAIL wrap_sum vld=%b sum=%h required vld=1 sum=80100000", f_sum_valid, f_sum_data);
    end
    f_take();
  endtask

  task automatic test_backpressure();
    f_beat(32'h0010_0000); f_beat(32'h0020_0000); f_beat(32'h0030_0000); f_beat(32'h0040_0000);
    f_in_valid = 1; f_in_data = 32'h0050_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({f_in_ready, f_sum_valid, f_busy} !== 3'b010 || f_sum_data !== 32'h00A0_0000) begin
        n_err++; $display("FAIL bp_hold%0d rdy/vld/busy=%b sum=%h required 010 sum=00a00000",
                          i, {f_in_ready, f_sum_valid, f_busy}, f_sum_data);
      end
    end
    f_sum_ready = 1; tick(); f_sum_ready = 0;
    n_cmp++;
    if ({f_sum_valid, f_in_ready, f_busy} !== 3'b010) begin
      n_err++; $display("FAIL bp_release vld/rdy/busy=%b required=010", {f_sum_valid, f_in_ready, f_busy});
    end
    tick(); f_in_valid = 0;
    n_cmp++;
    if (f_busy !== 1'b1) begin
      n_err++; $display("FAIL bp_first_beat busy=%b required=1", f_busy);
    end
    for (int i = 0; i < 3; i++) f_beat(32'h0010_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h0080_0000) begin
      n_err++; $display("FAIL bp_next_sum vld=%b sum=%h required vld=1 sum=00800000", f_sum_valid, f_sum_data);
    end
    f_take();
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) begin
      f_in_valid = 1; f_in_data = 32'h0010_0000; tick(); f_in_valid = 0;
      if (i < 3) begin
        tick();
        n_cmp++;
        if ({f_sum_valid, f_busy} !== 2'b01) begin
          n_err++; $display("FAIL gap_beat%0d vld/busy=%b required=01", i, {f_sum_valid, f_busy});
        end
      end
    end
    n_cmp++;
    if ({f_sum_valid, f_busy} !== 2'b10 || f_sum_data !== 32'h0040_0000) begin
      n_err++; $display("FAIL gap_sum vld/busy=%b sum=%h required 10 sum=00400000", {f_sum_valid, f_busy}, f_sum_data);
    end
    f_take();
  endtask

  task automatic test_flush();
    f_beat(32'h0030_0000); f_beat(32'h0030_0000);
    f_flush = 1; f_in_valid = 1; f_in_data = 32'h0070_0000; tick();
    f_flush = 0; f_in_valid = 0;
    n_cmp++;
    if ({f_sum_valid, f_in_ready, f_busy} !== 3'b010) begin
      n_err++; $display("FAIL flush_mid vld/rdy/busy=%b required=010", {f_sum_valid, f_in_ready, f_busy});
    end
    for (int i = 0; i < 4; i++) f_beat(32'h0010_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h0040_0000) begin
      n_err++; $display("FAIL flush_residue vld=%b sum=%h required vld=1 sum=00400000", f_sum_valid, f_sum_data);
    end
    f_flush = 1; f_sum_ready = 1; tick(); f_flush = 0; f_sum_ready = 0;
    n_cmp++;
    if ({f_sum_valid, f_in_ready, f_busy} !== 3'b010) begin
      n_err++; $display("FAIL flush_done vld/rdy/busy=%b required=010", {f_sum_valid, f_in_ready, f_busy});
    end
    for (int i = 0; i < 4; i++) f_beat(32'h0020_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h0080_0000) begin
      n_err++; $display("FAIL flush_next vld=%b sum=%h required vld=1 sum=00800000", f_sum_valid, f_sum_data);
    end
    f_take();
  endtask

  task automatic test_vec_len1();
    h_in_valid = 1; h_in_data = 32'h1234_5678; tick(); h_in_valid = 0;
    n_cmp++;
    if ({h_sum_valid, h_in_ready, h_busy} !== 3'b100 || h_sum_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL len1_pass vld/rdy/busy=%b sum=%h required 100 sum=12345678",
                        {h_sum_valid, h_in_ready, h_busy}, h_sum_data);
    end
    h_sum_ready = 1; tick(); h_sum_ready = 0;
    h_in_valid = 1; h_in_data = 32'hFFFF_FFFF; tick(); h_in_valid = 0;
    n_cmp++;
    if (h_sum_valid !== 1'b1 || h_sum_data !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL len1_second vld=%b sum=%h required vld=1 sum=ffffffff", h_sum_valid, h_sum_data);
    end
    h_sum_ready = 1; tick(); h_sum_ready = 0;
  endtask

  task automatic test_async_reset();
    f_beat(32'h0010_0000); f_beat(32'h0010_0000);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({f_in_ready, f_sum_valid, f_busy} !== 3'b000 || f_sum_data !== 32'h0) begin
      n_err++; $display("FAIL arst_mid rdy/vld/busy=%b sum=%h required 000 sum=00000000",
                        {f_in_ready, f_sum_valid, f_busy}, f_sum_data);
    end
    tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) f_beat(32'h0020_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h0080_0000) begin
      n_err++; $display("FAIL arst_after_mid vld=%b sum=%h required vld=1 sum=00800000", f_sum_valid, f_sum_data);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({f_in_ready, f_sum_valid, f_busy} !== 3'b000 || f_sum_data !== 32'h0) begin
      n_err++; $display("FAIL arst_done rdy/vld/busy=%b sum=%h required 000 sum=00000000",
                        {f_in_ready, f_sum_valid, f_busy}, f_sum_data);
    end
    tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) f_beat(32'h0010_0000);
    n_cmp++;
    if (f_sum_valid !== 1'b1 || f_sum_data !== 32'h0040_0000) begin
      n_err++; $display("FAIL arst_after_done vld=%b sum=%h required vld=1 sum=00400000", f_sum_valid, f_sum_data);
    end
    f_take();
  endtask

  initial begin
    test_reset();
    test_fixed_b2b();
    test_float();
    test_fixed_wrap();
    test_backpressure();
    test_gapped();
    test_flush();
    test_vec_len1();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
